// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single cycle (divides stay iterative).
module muldiv_unit #(
  parameter int unsigned ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  fncode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 5;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   acc;
  logic [W-1:0]    oper;
  logic [W-1:0]    dividend;
  logic            op_div, neg_res, neg_rem, div_zero;
  logic            busy_n, done_n;

  logic            is_mul, is_div, is_sgn, accept, accept_iter, accept_fast;
  logic [W-1:0]    a_abs, b_abs;

  assign is_mul = (fncode == FN_MULT) || (fncode == FN_MULTU);
  assign is_div = (fncode == FN_DIV)  || (fncode == FN_DIVU);
  assign is_sgn = (fncode == FN_MULT) || (fncode == FN_DIV);
  assign accept = start && (state_q == IDLE);
  assign a_abs  = (is_sgn && a[W-1]) ? W'(-a) : a;
  assign b_abs  = (is_sgn && b[W-1]) ? W'(-b) : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [DW-1:0] fast_prod;
  assign fast_prod   = is_sgn ? ({{W{a[W-1]}}, a} * {{W{b[W-1]}}, b})
                              : ({W'(0), a} * {W'(0), b});
  assign accept_iter = accept && is_div;
  assign accept_fast = accept && is_mul;
`else
  assign accept_iter = accept && (is_mul || is_div);
  assign accept_fast = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept_iter) state_n = ITER;
      ITER:    if (cnt == CW'(ITERS - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered status outputs
  always_comb begin
    busy_n = (state_n != IDLE);
    done_n = (state_q == FIX) || accept_fast;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_n;
      done <= done_n;
    end
  end

  // One shift-add or restoring shift-subtract step; acc holds {upper, lower} halves
  logic [W:0]    mul_upper, div_top, div_diff;
  logic [DW-1:0] step;
  always_comb begin
    mul_upper = {1'b0, acc[DW-1:W]} + (acc[0] ? {1'b0, oper} : {(W+1){1'b0}});
    div_top   = acc[DW-1:W-1];
    div_diff  = div_top - {1'b0, oper};
    if (op_div) begin
      if (div_top >= {1'b0, oper}) step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else                         step = {acc[DW-2:0], 1'b0};
    end else begin
      step = {mul_upper, acc[W-1:1]};
    end
  end

  // Sign fixup and special-case results applied when leaving FIX
  logic [DW-1:0] prod_fix;
  logic [W-1:0]  fix_hi, fix_lo;
  always_comb begin
    prod_fix = neg_res ? DW'(-acc) : acc;
    fix_hi   = prod_fix[DW-1:W];
    fix_lo   = prod_fix[W-1:0];
    if (op_div) begin
      if (div_zero) begin
        fix_hi = dividend;
        fix_lo = '1;
      end else begin
        fix_lo = neg_res ? W'(-acc[W-1:0])  : acc[W-1:0];
        fix_hi = neg_rem ? W'(-acc[DW-1:W]) : acc[DW-1:W];
      end
    end
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      oper     <= '0;
      dividend <= '0;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (accept && fncode == FN_MTHI) hi <= a;
      if (accept && fncode == FN_MTLO) lo <= a;
`ifdef MULDIV_FAST_MUL_EN
      if (accept_fast) begin
        hi <= fast_prod[DW-1:W];
        lo <= fast_prod[W-1:0];
      end
`endif
      if (accept_iter) begin
        op_div   <= is_div;
        oper     <= is_div ? b_abs : a_abs;
        acc      <= {W'(0), (is_div ? a_abs : b_abs)};
        dividend <= a;
        div_zero <= (b == '0);
        neg_res  <= is_sgn && (a[W-1] ^ b[W-1]);
        neg_rem  <= is_sgn && a[W-1];
        cnt      <= '0;
      end
      if (state_q == ITER) begin
        acc <= step;
        cnt <= cnt + CW'(1);
      end
      if (state_q == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the execute stage, alongside the ALU. It consumes the same register operands (a = rs, b = rt) and the same 6-bit MIPS funct code. It owns the HI/LO architectural registers and produces the values read by MFHI/MFLO. Control holds the pipeline while busy=1.

Parameters:
- ITERS, 32, number of shift iterations per MULT/DIV. Fixed to the operand width; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- fncode  input  6  MIPS funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13
- a  input  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  input  32  rt operand (multiplier / divisor)
- busy  output  1  operation in flight; start is ignored while high
- done  output  1  one-cycle pulse when HI/LO have just been updated by MULT/DIV
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset wins over all other inputs, including mid-operation; a partial result is discarded.
- States: IDLE, ITER, FIX.
- IDLE, start=1, fncode=MTHI/MTLO: hi (or lo) := a at that edge. busy stays 0, done stays 0. Single cycle.
- IDLE, start=1, fncode=MULT/MULTU/DIV/DIVU:
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch the result-sign flags.
  - Move to ITER, counter=0, busy=1.
- IDLE, start=1, any other fncode: ignored, no state change.
- ITER: one iteration per cycle, 32 cycles; counter 0..31; after counter=31, move to FIX.
  - Multiply: radix-2 shift-add into a 64-bit product.
  - Divide: restoring shift-subtract; 64-bit remainder/quotient register.
- FIX:
  - Apply sign fixup: negate the 64-bit product if signs differ; negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write hi/lo. MULT: hi=product[63:32], lo=product[31:0]. DIV: lo=quotient, hi=remainder.
  - Return to IDLE. done=1 and busy=0 in the following cycle.
- Latency: start accepted at edge E0; busy=1 after E0 through E33; hi/lo valid and done=1 after E33 (33 edges). done lasts exactly one cycle.
- A new start may be accepted in the same cycle that done=1; that cycle is in IDLE.
- hi/lo are stable throughout ITER/FIX, so MFHI/MFLO read the old values until done.
- Divide by zero (b=0), signed or unsigned: lo=0xFFFFFFFF, hi=a (unmodified dividend). No sign fixup. Same latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- start while busy=1: ignored, including MTHI/MTLO. No queueing.
- Arithmetic is modulo 2^64 for the product. Operands are treated as 32-bit two's complement for signed ops and unsigned otherwise.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full 64-bit product combinationally at acceptance.
  - hi/lo are written at E0, done=1 in the next cycle, and busy never asserts.
  - DIV/DIVU are unchanged (33 edges).
- Undefined: all four ops use the iterative 33-edge path described above.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE, b=0x00000003 -> busy for 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA. With MULDIV_FAST_MUL_EN defined, the result appears 1 cycle after start and busy stays 0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF while idle -> hi=0xDEADBEEF next cycle, busy=0. Then start DIV; an MTLO issued at cycle 5 is ignored and lo is only the DIV result.
- Start MULT, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. A subsequent MULTU 3*5 -> lo=15, hi=0.
